// File: rtl/if_stage_if.sv
// Fetch-stage bus: ROM port, downstream control and the IF/ID register outputs.
interface if_stage_if;
  logic [9:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        valid_out;
  logic        fault;

  modport master (
    output rom_addr, pc_out, inst_out, valid_out, fault,
    input  rom_rdata, stall, branch_taken, branch_target
  );
  modport slave (
    input  rom_addr, pc_out, inst_out, valid_out, fault,
    output rom_rdata, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID register and a BOOT/RUN/FAULT sequencer.
// Every output comes from a flop, so the redirect and stall inputs never reach an output combinationally.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  if_stage_if.master    bus
);
  localparam logic [31:0] PC_LIMIT = 32'(4 * ROM_WORDS);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] seq_pc;

  function automatic logic bad_pc(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= PC_LIMIT);
  endfunction

  assign seq_pc = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    case (state_q)
      BOOT: begin
        valid_d = 1'b0;
        if (bad_pc(pc_q)) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.branch_taken) begin
          valid_d = 1'b0;
          if (bad_pc(bus.branch_target)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = bus.branch_target;
          end
        end else if (!bus.stall) begin
          pc_out_d = pc_q;
          inst_d   = bus.rom_rdata;
          valid_d  = 1'b1;
          // The last legal word is still delivered; the fault flag follows a cycle later.
          if (bad_pc(seq_pc)) state_d = FAULT;
          else                pc_d    = seq_pc;
        end
      end
      default: begin
        fault_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      pc_out_q <= 32'd0;
      inst_q   <= 32'd0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.rom_addr  = pc_q[11:2];
  assign bus.pc_out    = pc_out_q;
  assign bus.inst_out  = inst_q;
  assign bus.valid_out = valid_q;
  assign bus.fault     = fault_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a transaction-level fetch model checked every cycle, plus literal spot checks.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  if_stage_if bus ();
  if_stage_if bus2 ();

  if_stage #(.RESET_PC(32'h0), .ROM_WORDS(1024)) dut (.clk(clk), .rst(rst), .bus(bus));
  if_stage #(.RESET_PC(32'h2), .ROM_WORDS(1024)) dut_bad (.clk(clk), .rst(rst), .bus(bus2));

  // ROM contents: word i holds i*0x11
  assign bus.rom_rdata      = {22'd0, bus.rom_addr} * 32'h11;
  assign bus2.rom_rdata     = 32'd0;
  assign bus2.stall         = 1'b0;
  assign bus2.branch_taken  = 1'b0;
  assign bus2.branch_target = 32'd0;

  // Model: phase 0 = waiting one cycle after reset, 1 = fetching, 2 = dead until reset
  int          m_ph;
  logic [31:0] m_pc, e_pc, e_inst;
  logic        e_valid, e_fault;

  function automatic logic illegal(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd4096);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_pc <= 32'h0; e_pc <= 32'h0; e_inst <= 32'h0;
      e_valid <= 1'b0; e_fault <= 1'b0;
    end else if (m_ph == 0) begin
      e_valid <= 1'b0;
      if (illegal(m_pc)) begin m_ph <= 2; e_fault <= 1'b1; end
      else m_ph <= 1;
    end else if (m_ph == 1) begin
      if (bus.branch_taken) begin
        e_valid <= 1'b0;
        if (illegal(bus.branch_target)) begin m_ph <= 2; e_fault <= 1'b1; end
        else m_pc <= bus.branch_target;
      end else if (!bus.stall) begin
        e_pc <= m_pc; e_inst <= (m_pc / 4) * 32'h11; e_valid <= 1'b1;
        if (illegal(m_pc + 32'd4)) m_ph <= 2;
        else m_pc <= m_pc + 32'd4;
      end
    end else begin
      e_fault <= 1'b1; e_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model.pc_out", bus.pc_out, e_pc);
    chk("model.inst_out", bus.inst_out, e_inst);
    chk("model.valid_out", {31'd0, bus.valid_out}, {31'd0, e_valid});
    chk("model.fault", {31'd0, bus.fault}, {31'd0, e_fault});
    chk("model.rom_addr", {22'd0, bus.rom_addr}, {22'd0, m_pc[11:2]});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    tick(2);
    chk("reset.pc_out", bus.pc_out, 32'h0);
    chk("reset.valid", {31'd0, bus.valid_out}, 32'd0);
    chk("reset.fault", {31'd0, bus.fault}, 32'd0);
    chk("reset.bad_fault", {31'd0, bus2.fault}, 32'd0);
    rst = 1'b0;

    tick(1);
    chk("boot.valid", {31'd0, bus.valid_out}, 32'd0);
    chk("boot.bad_resetpc_fault", {31'd0, bus2.fault}, 32'd1);
    tick(1);
    chk("c2.pc_out", bus.pc_out, 32'h0);
    chk("c2.inst", bus.inst_out, 32'h0);
    chk("c2.valid", {31'd0, bus.valid_out}, 32'd1);
    tick(1);
    chk("c3.pc_out", bus.pc_out, 32'h4);
    chk("c3.inst", bus.inst_out, 32'h11);
    tick(1);
    chk("c4.pc_out", bus.pc_out, 32'h8);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("stall.pc_out", bus.pc_out, 32'h8);
      chk("stall.inst", bus.inst_out, 32'h22);
      chk("stall.valid", {31'd0, bus.valid_out}, 32'd1);
    end
    bus.stall = 1'b0;
    tick(1);
    chk("unstall.pc_out", bus.pc_out, 32'hC);

    bus.branch_taken = 1'b1; bus.branch_target = 32'h100; bus.stall = 1'b1;
    tick(1);
    chk("br.bubble_valid", {31'd0, bus.valid_out}, 32'd0);
    chk("br.hold_pc_out", bus.pc_out, 32'hC);
    bus.branch_taken = 1'b0; bus.stall = 1'b0;
    tick(1);
    chk("br.pc_out", bus.pc_out, 32'h100);
    chk("br.inst", bus.inst_out, 32'h440);
    tick(2);

    // Asynchronous reset well away from any clock edge
    #1 rst = 1'b1;
    #1;
    chk("async.pc_out", bus.pc_out, 32'h0);
    chk("async.inst", bus.inst_out, 32'h0);
    chk("async.valid", {31'd0, bus.valid_out}, 32'd0);
    chk("async.rom_addr", {22'd0, bus.rom_addr}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("restart.pc_out", bus.pc_out, 32'h0);
    chk("restart.valid", {31'd0, bus.valid_out}, 32'd1);

    bus.branch_taken = 1'b1; bus.branch_target = 32'h102;
    tick(1);
    chk("mis.fault", {31'd0, bus.fault}, 32'd1);
    chk("mis.valid", {31'd0, bus.valid_out}, 32'd0);
    bus.branch_taken = 1'b0; bus.stall = 1'b1;
    tick(3);
    chk("mis.sticky", {31'd0, bus.fault}, 32'd1);
    bus.stall = 1'b0;
    reset_cycle();
    chk("mis.cleared", {31'd0, bus.fault}, 32'd0);

    bus.branch_taken = 1'b1; bus.branch_target = 32'h1000;
    tick(1);
    chk("oor.fault", {31'd0, bus.fault}, 32'd1);
    bus.branch_taken = 1'b0;
    tick(2);
    reset_cycle();

    bus.branch_taken = 1'b1; bus.branch_target = 32'hFF0;
    tick(1);
    bus.branch_taken = 1'b0;
    tick(4);
    chk("end.pc_out", bus.pc_out, 32'hFFC);
    chk("end.inst", bus.inst_out, 32'h43EF);
    chk("end.valid", {31'd0, bus.valid_out}, 32'd1);
    chk("end.fault_pending", {31'd0, bus.fault}, 32'd0);
    tick(1);
    chk("end.fault", {31'd0, bus.fault}, 32'd1);
    chk("end.valid_drop", {31'd0, bus.valid_out}, 32'd0);
    chk("end.pc_hold", bus.pc_out, 32'hFFC);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
